// File: rtl/threefish_pkg.sv
// Shared constants for the Threefish-1024 round datapath: geometry, round count
// and the MIX rotation table.
package threefish_pkg;

    localparam int unsigned WORD_W     = 64;
    localparam int unsigned NUM_WORDS  = 16;
    localparam int unsigned NUM_ROUNDS = 80;
    localparam int unsigned NUM_MIX    = NUM_WORDS / 2;
    localparam int unsigned ROUND_W    = 7;
    localparam int unsigned ROT_W      = 6;

    // Threefish-1024 rotation constants, indexed [d mod 8][mix index].
    localparam logic [ROT_W-1:0] ROT_TBL [8][8] = '{
        '{6'd24, 6'd13, 6'd8,  6'd47, 6'd8,  6'd17, 6'd22, 6'd37},
        '{6'd38, 6'd19, 6'd10, 6'd55, 6'd49, 6'd18, 6'd23, 6'd52},
        '{6'd33, 6'd4,  6'd51, 6'd13, 6'd34, 6'd41, 6'd59, 6'd17},
        '{6'd5,  6'd20, 6'd48, 6'd41, 6'd47, 6'd28, 6'd16, 6'd25},
        '{6'd41, 6'd9,  6'd37, 6'd31, 6'd12, 6'd47, 6'd44, 6'd30},
        '{6'd16, 6'd34, 6'd56, 6'd51, 6'd4,  6'd53, 6'd42, 6'd41},
        '{6'd31, 6'd44, 6'd47, 6'd46, 6'd19, 6'd42, 6'd44, 6'd25},
        '{6'd9,  6'd48, 6'd35, 6'd52, 6'd23, 6'd31, 6'd37, 6'd20}
    };

    function automatic logic [ROT_W-1:0] rot_sel(input logic [ROUND_W-1:0] d,
                                                 input int unsigned j);
        return ROT_TBL[3'(d % 7'd8)][3'(j % 8)];
    endfunction

endpackage

// File: rtl/threefish_mix_stage_if.sv
// Valid/ready handshake bundle on both sides of the MIX stage.
interface threefish_mix_stage_if import threefish_pkg::*; ();

    logic                          in_valid_i;
    logic                          in_ready_o;
    logic [NUM_WORDS*WORD_W-1:0]   in_words_i;
    logic [ROUND_W-1:0]            in_round_i;
    logic                          out_valid_o;
    logic                          out_ready_i;
    logic [NUM_WORDS*WORD_W-1:0]   out_words_o;
    logic [ROUND_W-1:0]            out_round_o;
    logic                          round_err_o;

    modport slave (
        input  in_valid_i, in_words_i, in_round_i, out_ready_i,
        output in_ready_o, out_valid_o, out_words_o, out_round_o, round_err_o
    );

    modport master (
        output in_valid_i, in_words_i, in_round_i, out_ready_i,
        input  in_ready_o, out_valid_o, out_words_o, out_round_o, round_err_o
    );

endinterface

// File: rtl/threefish_mix.sv
// Single combinational Threefish MIX: y0 = x0 + x1, y1 = rotl(x1, rot) ^ y0.
module threefish_mix
    import threefish_pkg::*;
(
    input  logic [WORD_W-1:0] x0,
    input  logic [WORD_W-1:0] x1,
    input  logic [ROT_W-1:0]  rot,
    output logic [WORD_W-1:0] y0,
    output logic [WORD_W-1:0] y1
);

    logic [WORD_W-1:0] x1_rot;

    // A rotate of 0 shifts right by the full width, which yields zero as intended.
    assign x1_rot = (x1 << rot) | (x1 >> (7'(WORD_W) - {1'b0, rot}));
    assign y0     = x0 + x1;
    assign y1     = x1_rot ^ y0;

endmodule

// File: rtl/threefish_mix_stage.sv
// Registered MIX stage of one Threefish-1024 round with valid/ready on both sides.
module threefish_mix_stage
    import threefish_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    threefish_mix_stage_if.slave  bus
);

    logic [NUM_WORDS*WORD_W-1:0] mix_words;
    logic                        in_fire;
    logic                        out_fire;

    assign bus.in_ready_o = !bus.out_valid_o || bus.out_ready_i;
    assign in_fire        = bus.in_valid_i && bus.in_ready_o;
    assign out_fire       = bus.out_valid_o && bus.out_ready_i;

    for (genvar j = 0; j < NUM_MIX; j++) begin : g_mix
        logic [ROT_W-1:0] rot;
        assign rot = rot_sel(bus.in_round_i, j);

        threefish_mix u_mix (
            .x0  (bus.in_words_i[(2*j)*WORD_W   +: WORD_W]),
            .x1  (bus.in_words_i[(2*j+1)*WORD_W +: WORD_W]),
            .rot (rot),
            .y0  (mix_words[(2*j)*WORD_W   +: WORD_W]),
            .y1  (mix_words[(2*j+1)*WORD_W +: WORD_W])
        );
    end

    // Accepting new data takes precedence over draining, giving one block per cycle.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            bus.out_valid_o <= 1'b0;
            bus.out_words_o <= '0;
            bus.out_round_o <= '0;
            bus.round_err_o <= 1'b0;
        end else begin
            if (in_fire) begin
                bus.out_valid_o <= 1'b1;
                bus.out_words_o <= mix_words;
                bus.out_round_o <= bus.in_round_i;
                if (bus.in_round_i >= ROUND_W'(NUM_ROUNDS)) begin
                    bus.round_err_o <= 1'b1;
                end
            end else if (out_fire) begin
                bus.out_valid_o <= 1'b0;
            end
        end
    end

endmodule
